// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: axis state encoding, standard mode
// constants and the line/frame total helper.
package vga_pkg;

   // Phase of one raster axis (horizontal or vertical)
   typedef enum logic [1:0] {
      ACTIVE,
      FP,
      SYNC,
      BP
   } axis_state_t;

   // 800x480 panel timing (the original fixed driver)
   localparam int unsigned VGA800_H_ACTIVE = 800;
   localparam int unsigned VGA800_H_FP     = 40;
   localparam int unsigned VGA800_H_SYNC   = 88;
   localparam int unsigned VGA800_H_BP     = 48;
   localparam int unsigned VGA800_V_ACTIVE = 480;
   localparam int unsigned VGA800_V_FP     = 13;
   localparam int unsigned VGA800_V_SYNC   = 3;
   localparam int unsigned VGA800_V_BP     = 32;

   // 640x480@60 industry timing
   localparam int unsigned VGA640_H_ACTIVE = 640;
   localparam int unsigned VGA640_H_FP     = 16;
   localparam int unsigned VGA640_H_SYNC   = 96;
   localparam int unsigned VGA640_H_BP     = 48;
   localparam int unsigned VGA640_V_ACTIVE = 480;
   localparam int unsigned VGA640_V_FP     = 10;
   localparam int unsigned VGA640_V_SYNC   = 2;
   localparam int unsigned VGA640_V_BP     = 33;

   // Limits: counters feed 11-bit pixel coordinates
   localparam int unsigned AXIS_MAX_TOTAL = 2048;
   localparam int unsigned PIX_LAT_MAX    = 4;

   // Total clocks (or lines) of one axis period
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter 0..TOTAL-1 plus the
// ACTIVE -> FP -> SYNC -> BP phase machine. Zero-length porches are skipped.
module vga_axis_counter #(
   parameter int unsigned ACTIVE = 800,
   parameter int unsigned FP     = 40,
   parameter int unsigned SYNC   = 88,
   parameter int unsigned BP     = 48,
   localparam int unsigned TOTAL = vga_pkg::axis_total(ACTIVE, FP, SYNC, BP),
   localparam int unsigned W     = $clog2(TOTAL)
) (
   input  logic                 RESET,
   input  logic                 VGA_CLOCK,
   input  logic                 advance,
   output logic [W-1:0]         count,
   output vga_pkg::axis_state_t state,
   output logic                 wrap
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   if (ACTIVE == 0 || SYNC == 0) begin : g_bad_len
      $fatal(1, "vga_axis_counter: active and sync lengths must be non-zero");
   end
   if (TOTAL > vga_pkg::AXIS_MAX_TOTAL) begin : g_bad_total
      $fatal(1, "vga_axis_counter: axis total exceeds 2048");
   end

   logic [W-1:0] seg;

   // Last in-state count of a phase; zero-length porches are never entered
   function automatic logic [W-1:0] seg_last(input vga_pkg::axis_state_t s);
      case (s)
         vga_pkg::ACTIVE: seg_last = W'(ACTIVE - 1);
         vga_pkg::FP:     seg_last = W'(FP - 1);
         vga_pkg::SYNC:   seg_last = W'(SYNC - 1);
         default:         seg_last = W'(BP - 1);
      endcase
   endfunction

   // Successor phase, skipping any porch of length zero
   function automatic vga_pkg::axis_state_t next_state(input vga_pkg::axis_state_t s);
      case (s)
         vga_pkg::ACTIVE: next_state = (FP != 0) ? vga_pkg::FP : vga_pkg::SYNC;
         vga_pkg::FP:     next_state = vga_pkg::SYNC;
         vga_pkg::SYNC:   next_state = (BP != 0) ? vga_pkg::BP : vga_pkg::ACTIVE;
         default:         next_state = vga_pkg::ACTIVE;
      endcase
   endfunction

   // Position counter and phase machine, stepping only when advanced
   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET) begin
         count <= '0;
         seg   <= '0;
         state <= vga_pkg::ACTIVE;
      end else if (advance) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
         if (seg == seg_last(state)) begin
            seg   <= '0;
            state <= next_state(state);
         end else begin
            seg <= seg + 1'b1;
         end
      end
   end

   // Wrap strobe: this advance takes the counter back to zero
   always_comb begin
      wrap = advance && (count == LAST);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: registered pixel-request stage and a
// (PIX_LAT+1)-deep output delay line keeping sync, DE and colour aligned.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA800_H_ACTIVE,
   parameter int unsigned H_FP     = VGA800_H_FP,
   parameter int unsigned H_SYNC   = VGA800_H_SYNC,
   parameter int unsigned H_BP     = VGA800_H_BP,
   parameter int unsigned V_ACTIVE = VGA800_V_ACTIVE,
   parameter int unsigned V_FP     = VGA800_V_FP,
   parameter int unsigned V_SYNC   = VGA800_V_SYNC,
   parameter int unsigned V_BP     = VGA800_V_BP,
   parameter int unsigned HS_POL   = 1,
   parameter int unsigned VS_POL   = 1,
   parameter int unsigned CBITS    = 1,
   parameter int unsigned PIX_LAT  = 1
) (
   input  logic               RESET,
   input  logic               VGA_CLOCK,
   input  logic [3*CBITS-1:0] PIXEL,
   output logic               PIXEL_REQ,
   output logic [10:0]        PIXEL_H,
   output logic [10:0]        PIXEL_V,
   output logic               FRAME_START,
   output logic               LINE_START,
   output logic [CBITS-1:0]   VGA_RED,
   output logic [CBITS-1:0]   VGA_GREEN,
   output logic [CBITS-1:0]   VGA_BLUE,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_DE
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam logic        HS_LVL  = 1'(HS_POL);
   localparam logic        VS_LVL  = 1'(VS_POL);

   if (PIX_LAT > PIX_LAT_MAX) begin : g_bad_lat
      $fatal(1, "vga_timing_gen: PIX_LAT must be 0..4");
   end
   if (CBITS == 0) begin : g_bad_cbits
      $fatal(1, "vga_timing_gen: CBITS must be non-zero");
   end

   logic [HW-1:0] h_count;
   logic [VW-1:0] v_count;
   axis_state_t   h_state;
   axis_state_t   v_state;
   logic          h_wrap;
   logic          v_wrap_unused;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .RESET     (RESET),
      .VGA_CLOCK (VGA_CLOCK),
      .advance   (1'b1),
      .count     (h_count),
      .state     (h_state),
      .wrap      (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .RESET     (RESET),
      .VGA_CLOCK (VGA_CLOCK),
      .advance   (h_wrap),
      .count     (v_count),
      .state     (v_state),
      .wrap      (v_wrap_unused)
   );

   logic visible;
   logic hs_req;
   logic vs_req;

   // Visible region: both axes in their active phase
   always_comb begin
      visible = (h_state == ACTIVE) && (v_state == ACTIVE);
   end

   // Request stage: coordinates and markers for the current raster position
   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET) begin
         PIXEL_REQ   <= 1'b0;
         PIXEL_H     <= '0;
         PIXEL_V     <= '0;
         FRAME_START <= 1'b0;
         LINE_START  <= 1'b0;
         hs_req      <= 1'b0;
         vs_req      <= 1'b0;
      end else begin
         PIXEL_REQ   <= visible;
         PIXEL_H     <= visible ? 11'(h_count) : '0;
         PIXEL_V     <= visible ? 11'(v_count) : '0;
         FRAME_START <= visible && (h_count == '0) && (v_count == '0);
         LINE_START  <= visible && (h_count == '0);
         hs_req      <= (h_state == SYNC);
         vs_req      <= (v_state == SYNC);
      end
   end

   // Delay line entries hold "asserted" flags; reset clears them to idle
   logic [PIX_LAT:0] de_line;
   logic [PIX_LAT:0] hs_line;
   logic [PIX_LAT:0] vs_line;

   // Output delay line: request-stage flags shifted PIX_LAT+1 clocks
   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET) begin
         de_line <= '0;
         hs_line <= '0;
         vs_line <= '0;
      end else begin
         de_line[0] <= PIXEL_REQ;
         hs_line[0] <= hs_req;
         vs_line[0] <= vs_req;
         for (int unsigned i = 1; i <= PIX_LAT; i++) begin
            de_line[i] <= de_line[i-1];
            hs_line[i] <= hs_line[i-1];
            vs_line[i] <= vs_line[i-1];
         end
      end
   end

   // Request flag aligned with the cycle in which PIXEL answers it
   logic de_tap;
   if (PIX_LAT == 0) begin : g_tap_direct
      // Request flag of the same cycle the client answers in
      always_comb begin
         de_tap = PIXEL_REQ;
      end
   end else begin : g_tap_line
      // Request flag delayed to meet the client's read latency
      always_comb begin
         de_tap = de_line[PIX_LAT-1];
      end
   end

   logic [3*CBITS-1:0] colour;

   // Colour register: capture PIXEL only for requested pixels, else black
   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET) begin
         colour <= '0;
      end else begin
         colour <= de_tap ? PIXEL : '0;
      end
   end

   // Pin drive: tail of the delay line, sync mapped to configured polarity
   always_comb begin
      VGA_DE                         = de_line[PIX_LAT];
      VGA_HS                         = hs_line[PIX_LAT] ^ ~HS_LVL;
      VGA_VS                         = vs_line[PIX_LAT] ^ ~VS_LVL;
      {VGA_RED, VGA_GREEN, VGA_BLUE} = colour;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with a pixel-request interface and a fixed-latency return path.
- Generalises the fixed 800x480 3-bit driver: timing, sync polarity, colour depth and client read latency are all parameters.
- Sits between the clocking block and pixel sources (pong renderer, future framebuffer reader); drives the VGA connector pins directly.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 88, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 13, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BP, 32, vertical back porch (lines)
HS_POL, 1, HS asserted level (1 = active-high)
VS_POL, 1, VS asserted level
CBITS, 1, bits per colour channel
PIX_LAT, 1, clocks from request to PIXEL valid (0..4)

Ports:
RESET  in  1  asynchronous, active-high reset
VGA_CLOCK  in  1  pixel clock
PIXEL  in  3*CBITS  {R,G,B}; valid PIX_LAT clocks after its request
PIXEL_REQ  out  1  PIXEL_H/V name a visible pixel
PIXEL_H  out  11  requested column, 0 when PIXEL_REQ low
PIXEL_V  out  11  requested line, 0 when PIXEL_REQ low
FRAME_START  out  1  one-clock pulse with request of pixel (0,0)
LINE_START  out  1  one-clock pulse with request of column 0 of every visible line
VGA_RED  out  CBITS  red
VGA_GREEN  out  CBITS  green
VGA_BLUE  out  CBITS  blue
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
VGA_DE  out  1  data enable, aligned with colour

Behaviour:
- Reset is RESET, asynchronous, active-high; the clock is VGA_CLOCK. All registers are reset.
- Counter h runs 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters. It wraps to 0 after H_TOTAL-1.
- Counter v increments when h wraps and itself wraps after V_TOTAL-1. The 800/40/88/48 and 480/13/3/32 defaults give 976x528.
- Each axis is a state machine ACTIVE -> FP -> SYNC -> BP -> ACTIVE:
  - It leaves a state when its in-state count reaches the state length minus 1.
  - The V machine advances only on h wrap.
  - A zero-length porch is skipped: the transition goes straight to the next non-zero state.
- Sync is asserted while the axis is in SYNC. HS is h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. VS applies the same rule on v.
- Visible = both axes in ACTIVE (h < H_ACTIVE and v < V_ACTIVE).
- Timing reference: counter value k is present in cycle k after reset release (h=0, v=0 in the first cycle).
- Request stage is registered; the counter value of cycle k appears in cycle k+1:
  - PIXEL_REQ = visible.
  - PIXEL_H/V = h/v when visible, else 0. Values are zero-extended to 11 bits.
  - FRAME_START = visible and h=0 and v=0.
  - LINE_START = visible and h=0.
- PIXEL is sampled PIX_LAT clocks after the matching request cycle.
- Output stage is registered:
  - VGA colour = PIXEL when the delayed REQ is high, else 0.
  - HS, VS and REQ go through a (PIX_LAT+1)-deep delay line, so HS/VS/DE/colour are mutually aligned.
  - Total latency from counter to pins = PIX_LAT+2 clocks.
- Sync outputs drive the polarity level when asserted and the inverse otherwise.
- Reset values:
  - Counters and states at h=0, v=0 (ACTIVE/ACTIVE).
  - PIXEL_REQ, FRAME_START, LINE_START = 0; PIXEL_H/V = 0.
  - Colour = 0; VGA_DE = 0.
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL. Delay-line contents are cleared to the deasserted values.
- Reset mid-frame: every output returns to its reset value asynchronously. The first pixel after release is (0,0) and FRAME_START asserts in release cycle +1.
- Simultaneous h wrap and v wrap in one clock: both counters go to 0 and the next request is (0,0).
- Elaboration check: any active or sync length of 0, or PIX_LAT > 4, is a fatal error.
- Counter widths: $clog2(H_TOTAL) and $clog2(V_TOTAL). H_TOTAL and V_TOTAL must each be at most 2048.

Decomposition:
- Package vga_pkg holds:
  - axis state enum {ACTIVE, FP, SYNC, BP};
  - default timing constants for 800x480 and 640x480@60 (640/16/96/48, 480/10/2/33);
  - function axis_total().
- Sub-module vga_axis_counter, instantiated twice (H and V):
  - parameters ACTIVE/FP/SYNC/BP;
  - inputs RESET, VGA_CLOCK, advance;
  - outputs count, state, wrap.
- Top level holds the request-stage registers and the output delay line.

Test Plan:
- Default parameters, PIX_LAT=1, release reset:
  - first PIXEL_REQ and FRAME_START at cycle 1 with H=0, V=0;
  - LINE_START every 976 clocks; PIXEL_REQ high 800 clocks per line.
- Same run: VGA_HS rises at cycle 843 and falls at cycle 931 (88 clocks wide); VGA_VS high for lines 493..495; frame period 976*528 = 515328 clocks.
- Return PIXEL = {PIXEL_H[0], PIXEL_V[0], 1} with PIX_LAT=3:
  - VGA_DE and colour at pins match counter position k at cycle k+5;
  - colour is 0 whenever VGA_DE=0, even if PIXEL is all ones.
- HS_POL=0, VS_POL=0, CBITS=4, 640x480 constants: idle HS/VS high at reset; HS low for exactly 96 clocks per 800-clock line; blue carries 4-bit value 0xA unchanged.
- Assert RESET at h=300, v=200 for 2 clocks: all outputs go to reset values immediately; FRAME_START is seen one cycle after release; a full frame follows.
- H_FP=0, V_BP=0: sync starts directly after the active region (HS rises at pin cycle H_ACTIVE+PIX_LAT+2); no counter glitch at the wraps.
